// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU with NZCV status register, branch target,
// and the EXE/MEM pipeline register. Define EXE_FWD_EN to enable operand forwarding.
module exe_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          WB_EN,
  input  logic          MEM_R_EN,
  input  logic          MEM_W_EN,
  input  logic          B,
  input  logic          S,
  input  logic [3:0]    EXE_CMD,
  input  logic [DW-1:0] PC,
  input  logic [DW-1:0] Val_Rn,
  input  logic [DW-1:0] Val_Rm,
  input  logic          imm,
  input  logic [11:0]   Shift_operand,
  input  logic [23:0]   Signed_imm_24,
  input  logic [3:0]    Dest,
  input  logic [1:0]    sel_src1,
  input  logic [1:0]    sel_src2,
  input  logic [DW-1:0] fwd_mem_val,
  input  logic [DW-1:0] fwd_wb_val,
  output logic [3:0]    SR,
  output logic          branch_taken,
  output logic [DW-1:0] branch_addr,
  output logic          WB_EN_MEM,
  output logic          MEM_R_EN_MEM,
  output logic          MEM_W_EN_MEM,
  output logic [DW-1:0] ALU_res_MEM,
  output logic [DW-1:0] Val_Rm_MEM,
  output logic [3:0]    Dest_MEM
);

  logic [DW-1:0] op1;
  logic [DW-1:0] op2m;

`ifdef EXE_FWD_EN
  logic unused_bits;
  assign unused_bits = Shift_operand[4];

  always_comb begin
    case (sel_src1)
      2'b01:   op1 = fwd_mem_val;
      2'b10:   op1 = fwd_wb_val;
      default: op1 = Val_Rn;
    endcase
    case (sel_src2)
      2'b01:   op2m = fwd_mem_val;
      2'b10:   op2m = fwd_wb_val;
      default: op2m = Val_Rm;
    endcase
  end
`else
  logic unused_bits;
  assign unused_bits = Shift_operand[4] ^ (^sel_src1) ^ (^sel_src2)
                     ^ (^fwd_mem_val) ^ (^fwd_wb_val);
  assign op1  = Val_Rn;
  assign op2m = Val_Rm;
`endif

  // Rotations are built from two opposing shifts; a zero amount leaves the value intact
  // because the left shift by the full width clears to zero.
  logic [4:0]    rot_amt;
  logic [4:0]    sh_amt;
  logic [DW-1:0] imm8;
  logic [DW-1:0] imm_rot;
  logic [DW-1:0] reg_rot;
  logic [DW-1:0] val2;

  assign imm8    = {{(DW-8){1'b0}}, Shift_operand[7:0]};
  assign rot_amt = {Shift_operand[11:8], 1'b0};
  assign sh_amt  = Shift_operand[11:7];
  assign imm_rot = (imm8 >> rot_amt) | (imm8 << (6'(DW) - {1'b0, rot_amt}));
  assign reg_rot = (op2m >> sh_amt) | (op2m << (6'(DW) - {1'b0, sh_amt}));

  always_comb begin
    val2 = op2m;
    if (imm) begin
      val2 = imm_rot;
    end else if (MEM_R_EN || MEM_W_EN) begin
      val2 = {{(DW-12){1'b0}}, Shift_operand};
    end else begin
      case (Shift_operand[6:5])
        2'b00:   val2 = op2m << sh_amt;
        2'b01:   val2 = op2m >> sh_amt;
        2'b10:   val2 = $signed(op2m) >>> sh_amt;
        default: val2 = reg_rot;
      endcase
    end
  end

  logic [3:0]  sr_q, sr_d;
  logic [DW:0] sum;
  logic [DW-1:0] alu_res;
  logic        c_new, v_new, op_valid, cin;

  assign cin = sr_q[1];

  // Subtracts add the inverted operand plus one, so the carry out is NOT borrow.
  always_comb begin
    sum      = '0;
    alu_res  = '0;
    c_new    = sr_q[1];
    v_new    = sr_q[0];
    op_valid = 1'b1;
    case (EXE_CMD)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011: begin
        sum     = {1'b0, op1} + {1'b0, val2}
                + {{DW{1'b0}}, (EXE_CMD == 4'b0011) & cin};
        alu_res = sum[DW-1:0];
        c_new   = sum[DW];
        v_new   = (op1[DW-1] == val2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
      end
      4'b0100, 4'b0101: begin
        sum     = {1'b0, op1} + {1'b0, ~val2}
                + {{DW{1'b0}}, (EXE_CMD == 4'b0100) | cin};
        alu_res = sum[DW-1:0];
        c_new   = sum[DW];
        v_new   = (op1[DW-1] != val2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
      end
      4'b0110: alu_res = op1 & val2;
      4'b0111: alu_res = op1 | val2;
      4'b1000: alu_res = op1 ^ val2;
      default: op_valid = 1'b0;
    endcase
  end

  logic [DW-1:0] alu_res_q, alu_res_d;
  logic [DW-1:0] val_rm_q, val_rm_d;
  logic [3:0]    dest_q, dest_d;
  logic          wb_en_q, wb_en_d;
  logic          mem_r_en_q, mem_r_en_d;
  logic          mem_w_en_q, mem_w_en_d;

  always_comb begin
    sr_d       = sr_q;
    alu_res_d  = alu_res_q;
    val_rm_d   = val_rm_q;
    dest_d     = dest_q;
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    mem_w_en_d = mem_w_en_q;
    if (!freeze) begin
      if (S && op_valid) begin
        sr_d = {alu_res[DW-1], (alu_res == '0), c_new, v_new};
      end
      alu_res_d  = alu_res;
      val_rm_d   = op2m;
      dest_d     = Dest;
      wb_en_d    = WB_EN;
      mem_r_en_d = MEM_R_EN;
      mem_w_en_d = MEM_W_EN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
    end
  end

  assign SR           = sr_q;
  assign ALU_res_MEM  = alu_res_q;
  assign Val_Rm_MEM   = val_rm_q;
  assign Dest_MEM     = dest_q;
  assign WB_EN_MEM    = wb_en_q;
  assign MEM_R_EN_MEM = mem_r_en_q;
  assign MEM_W_EN_MEM = mem_w_en_q;

  assign branch_taken = B;
  assign branch_addr  = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

endmodule
